// File: rtl/rr_onehot_mux_arbiter_pkg.sv
// Shared arbitration types and helpers used by the round-robin arbiters in this tree.
package rr_onehot_mux_arbiter_pkg;

  localparam int MAX_CNT = 32;
  localparam int IDX_W   = $clog2(MAX_CNT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // One-hot of the lowest set mask bit, searched circularly from (from+1) mod cnt.
  function automatic logic [MAX_CNT-1:0] rr_pick(input logic [MAX_CNT-1:0] mask,
                                                input int from, input int cnt);
    logic [MAX_CNT-1:0] pick;
    logic               found;
    int                 jj;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_CNT; k++) begin
      jj = from + k;
      if (jj >= cnt) jj = jj - cnt;
      if (k <= cnt && !found && mask[IDX_W'(jj)]) begin
        pick[IDX_W'(jj)] = 1'b1;
        found            = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CNT-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CNT; i++)
      if (oh[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/one_hot_mux.sv
// AND-OR data mux driven by a one-hot select, with an optional one-hot violation flag.
module one_hot_mux #(
  parameter int WIDTH         = 32,
  parameter int CNT           = 5,
  parameter bit ONE_HOT_CHECK = 1'b1
) (
  input  logic [CNT-1:0]       sel,
  input  logic [WIDTH*CNT-1:0] din,
  output logic [WIDTH-1:0]     dout,
  output logic                 err
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < CNT; i++)
      if (sel[i]) dout = dout | din[i*WIDTH +: WIDTH];
  end

  // More than one select bit set means two sources are being ORed together.
  assign err = ONE_HOT_CHECK && ((sel & (sel - CNT'(1))) != '0);

endmodule

// File: rtl/rr_onehot_mux_arbiter.sv
// Round-robin arbiter with bounded bursts sharing a one-hot mux onto one valid/ready output.
module rr_onehot_mux_arbiter
  import rr_onehot_mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT   = 5,
  parameter int BURST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT-1:0]       req,
  input  logic [WIDTH*CNT-1:0] din,
  output logic [CNT-1:0]       ack,
  output logic [CNT-1:0]       gnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     dout,
  output logic                 err
);

  localparam int PW = $clog2(CNT);
  localparam int BW = $clog2(BURST + 1);

  // Handshake: a beat moves when out_valid & out_ready; ack is that event on the granted lane.
  arb_state_t         state, state_n;
  logic [CNT-1:0]     gnt_q, gnt_n;
  logic [PW-1:0]      ptr, ptr_n;
  logic [BW-1:0]      beat_cnt, beat_n;
  logic [MAX_CNT-1:0] req_w, oth_w, pick_w;
  logic               take;
  logic [CNT-1:0]     sel;

  assign req_w = MAX_CNT'(req);
  assign oth_w = MAX_CNT'(req & ~gnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      ptr      <= PW'(CNT - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt_q    <= gnt_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_n;
    end
  end

  // In BUSY, ptr always holds the granted index, so it doubles as g.
  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    ptr_n   = ptr;
    beat_n  = beat_cnt;
    pick_w  = '0;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          pick_w = rr_pick(req_w, int'(ptr), CNT);
          take   = 1'b1;
        end
      end
      BUSY: begin
        if (!(|(gnt_q & req))) begin
          if (|req) begin
            pick_w = rr_pick(req_w, int'(ptr), CNT);
            take   = 1'b1;
          end else begin
            gnt_n   = '0;
            beat_n  = '0;
            state_n = IDLE;
          end
        end else if (out_ready) begin
          if (int'(beat_cnt) + 1 < BURST) begin
            beat_n = beat_cnt + BW'(1);
          end else if (oth_w != '0) begin
            pick_w = rr_pick(oth_w, int'(ptr), CNT);
            take   = 1'b1;
          end else begin
            beat_n = '0;
          end
        end
      end
      default: ;
    endcase
    if (take) begin
      gnt_n   = pick_w[CNT-1:0];
      ptr_n   = PW'(onehot_to_idx(pick_w));
      beat_n  = '0;
      state_n = BUSY;
    end
  end

  // Outputs are forced quiet during any reset cycle so no beat is accepted mid-reset.
  always_comb begin
    sel       = rst ? '0 : gnt_q;
    gnt       = sel;
    out_valid = |(sel & req);
    ack       = sel & {CNT{out_ready}} & req;
  end

  one_hot_mux #(
    .WIDTH         (WIDTH),
    .CNT           (CNT),
    .ONE_HOT_CHECK (1'b1)
  ) u_mux (
    .sel  (sel),
    .din  (din),
    .dout (dout),
    .err  (err)
  );

endmodule

// File: tb/tb_rr_onehot_mux_arbiter.sv
// Drives three arbiter instances (BURST 1, 2, 4) from shared inputs against a behavioural model.
module tb_rr_onehot_mux_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT   = 5;
  localparam int NI    = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CNT-1:0]       req;
  logic [WIDTH*CNT-1:0] din;
  logic                 out_ready;

  logic [CNT-1:0]   ack_w  [NI];
  logic [CNT-1:0]   gnt_w  [NI];
  logic             ov_w   [NI];
  logic [WIDTH-1:0] dout_w [NI];
  logic             err_w  [NI];

  int burst_len [NI] = '{1, 2, 4};
  int mg   [NI];
  int mptr [NI];
  int mbeat[NI];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rr_onehot_mux_arbiter #(.WIDTH(WIDTH), .CNT(CNT), .BURST(1)) dut_b1 (
    .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack_w[0]), .gnt(gnt_w[0]),
    .out_valid(ov_w[0]), .out_ready(out_ready), .dout(dout_w[0]), .err(err_w[0]));
  rr_onehot_mux_arbiter #(.WIDTH(WIDTH), .CNT(CNT), .BURST(2)) dut_b2 (
    .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack_w[1]), .gnt(gnt_w[1]),
    .out_valid(ov_w[1]), .out_ready(out_ready), .dout(dout_w[1]), .err(err_w[1]));
  rr_onehot_mux_arbiter #(.WIDTH(WIDTH), .CNT(CNT), .BURST(4)) dut_b4 (
    .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack_w[2]), .gnt(gnt_w[2]),
    .out_valid(ov_w[2]), .out_ready(out_ready), .dout(dout_w[2]), .err(err_w[2]));

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[inst %0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic int rr(input int mask, input int from);
    for (int k = 1; k <= CNT; k++) begin
      int j;
      j = (from + k) % CNT;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  task automatic check_inst(input int k);
    logic [31:0] eg, ea, ed;
    logic        ev;
    eg = 0; ea = 0; ed = 0; ev = 1'b0;
    if (!rst && mg[k] >= 0) begin
      eg = 32'(1) << mg[k];
      ed = din[mg[k]*WIDTH +: WIDTH];
      ev = req[mg[k]];
      if (ev && out_ready) ea = eg;
    end
    chk("gnt", k, 32'(gnt_w[k]), eg);
    chk("ack", k, 32'(ack_w[k]), ea);
    chk("out_valid", k, 32'(ov_w[k]), 32'(ev));
    chk("dout", k, dout_w[k], ed);
    chk("err", k, 32'(err_w[k]), 32'd0);
  endtask

  task automatic model_step(input int k);
    int r, others;
    r = int'(req);
    if (rst) begin
      mg[k] = -1; mptr[k] = CNT - 1; mbeat[k] = 0;
    end else if (mg[k] < 0) begin
      if (r != 0) begin mg[k] = rr(r, mptr[k]); mptr[k] = mg[k]; mbeat[k] = 0; end
    end else if (!r[mg[k]]) begin
      mbeat[k] = 0;
      if (r != 0) begin mg[k] = rr(r, mg[k]); mptr[k] = mg[k]; end
      else mg[k] = -1;
    end else if (out_ready) begin
      if (mbeat[k] + 1 < burst_len[k]) mbeat[k]++;
      else begin
        mbeat[k] = 0;
        others = r & ~(1 << mg[k]);
        if (others != 0) begin mg[k] = rr(others, mg[k]); mptr[k] = mg[k]; end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [CNT-1:0] q, input logic rdy, input bit rand_din);
    @(negedge clk);
    rst = r; req = q; out_ready = rdy;
    if (rand_din)
      for (int i = 0; i < CNT; i++) din[i*WIDTH +: WIDTH] = $urandom;
    #1;
    for (int k = 0; k < NI; k++) check_inst(k);
    for (int k = 0; k < NI; k++) model_step(k);
  endtask

  initial begin
    logic [CNT-1:0] seq [6];
    seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    rst = 1'b1; req = '0; out_ready = 1'b0;
    for (int i = 0; i < CNT; i++) din[i*WIDTH +: WIDTH] = 32'hA0 + i;
    for (int k = 0; k < NI; k++) begin mg[k] = -1; mptr[k] = CNT - 1; mbeat[k] = 0; end

    // Per-beat round robin with fixed slice data.
    cycle(1, '0, 1, 0);
    cycle(1, '0, 1, 0);
    cycle(0, 5'b11111, 1, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 5'b11111, 1, 0);
      chk("seq_gnt", 0, 32'(gnt_w[0]), 32'(seq[i]));
      chk("seq_dout", 0, dout_w[0], 32'hA0 + 32'(i % CNT));
    end

    // Two requesters held: bursts alternate with no bubble.
    cycle(1, '0, 1, 0);
    cycle(0, 5'b01100, 1, 0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 5'b01100, 1, 1);
      chk("burst_valid", 2, 32'(ov_w[2]), 32'd1);
    end

    // Backpressure on index 1, then drop req while index 3 waits, then go idle.
    cycle(1, '0, 1, 0);
    cycle(0, 5'b00010, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 5'b00010, 0, 1);
    cycle(0, 5'b00010, 1, 1);
    cycle(0, 5'b00010, 0, 1);
    cycle(0, 5'b01000, 0, 1);
    cycle(0, 5'b01000, 0, 1);
    cycle(0, 5'b00000, 0, 1);
    cycle(0, 5'b00000, 1, 1);

    // Lone requester streams continuously.
    for (int i = 0; i < 6; i++) cycle(0, 5'b00100, 1, 1);

    // Reset in the middle of a burst, then restart from all requesting.
    cycle(1, '0, 1, 0);
    cycle(0, 5'b11111, 1, 1);
    cycle(0, 5'b11111, 1, 1);
    cycle(0, 5'b11111, 1, 1);
    cycle(1, 5'b11111, 1, 1);
    cycle(0, 5'b11111, 1, 1);
    cycle(0, 5'b11111, 1, 1);
    chk("post_reset_gnt", 2, 32'(gnt_w[2]), 32'd1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 39) == 0, CNT'($urandom), $urandom_range(0, 3) != 0, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
